dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares the single-port data memory between the communication interface (program load / result dump) and N processor cores.
- Grants one memory transaction per cycle and drives the DM address, write-data and write-enable lines.
- Routes the synchronous read data back to the requester that issued the read, with a registered valid strobe.
- Sits between the com block, the cores and the DM. Replaces the static status-driven mux with a dynamic arbiter.

Parameters:
- N_CORES, 2, number of core requesters (2..8).
- ADDR_W, 16, DM address width.
- DATA_W, 16, DM data width.
- MAX_COM_BURST, 8, consecutive com grants allowed while a core waits (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- com_req  in  1  com transaction request, level, held until granted.
- com_wr_en  in  1  1 = write, 0 = read.
- com_addr  in  ADDR_W  com address.
- com_data_in  in  DATA_W  com write data.
- com_gnt  out  1  com request accepted this cycle.
- com_rvalid  out  1  com_data_out valid.
- com_data_out  out  DATA_W  read data to com.
- core_req  in  N_CORES  per-core request.
- core_wr_en  in  N_CORES  per-core write flag.
- core_addr  in  N_CORES*ADDR_W  packed addresses; core i at bits [i*ADDR_W +: ADDR_W].
- core_data_in  in  N_CORES*DATA_W  packed write data.
- core_gnt  out  N_CORES  one-hot grant.
- core_rvalid  out  N_CORES  one-hot read-data valid.
- core_data_out  out  DATA_W  read data, shared by all cores, qualified by core_rvalid.
- DM_addr  out  ADDR_W  memory address.
- DM_data_in  out  DATA_W  memory write data.
- DM_write_en  out  1  memory write strobe.
- DM_out  in  DATA_W  memory read data, valid one cycle after the address is presented.
- status  out  2  registered type of last cycle's grant: 00 com write, 01 core, 10 com read, 11 idle.

Behaviour:
- Clock and reset: clk with a synchronous active-high reset rst. On rst every output is held at its reset value:
  - all gnt and rvalid outputs 0;
  - DM_write_en 0; DM_addr 0; DM_data_in 0;
  - status 11;
  - com_data_out 0; core_data_out 0.
  - rr_ptr resets to 0.
- Arbitration is combinational within the cycle and grants at most one requester.
- Priority: com first. Cores are served round-robin starting at rr_ptr.
- On a core i grant, rr_ptr becomes (i+1) mod N_CORES at the clock edge. rr_ptr is unchanged on a com grant or an idle cycle.
- DM_addr, DM_data_in and DM_write_en mux combinationally from the granted requester.
- DM_write_en = gnt & wr_en. With no grant: DM_write_en 0, DM_addr and DM_data_in 0.
- Handshake: a request is consumed in any cycle where its gnt is 1. The requester may change or drop req the next cycle. req must not depend combinationally on gnt.
- Read pipeline:
  - A read granted in cycle t asserts the matching rvalid in cycle t+1 for exactly 1 cycle.
  - Data is passed through: com_data_out / core_data_out = DM_out in that cycle, else held at the last value.
  - Back-to-back reads to different requesters are legal every cycle.
- Writes produce no rvalid.
- status register is updated every cycle from the grant type.
- Simultaneous com and core requests: com wins; cores wait, and rr_ptr is not updated.
- Reset mid-read: if rst is asserted in cycle t+1, rvalid stays 0 and the read is dropped.

Optional Feature:
- Macro: DM_ARB_STARVE_GUARD_EN.
- When defined, a counter (width clog2(MAX_COM_BURST+1)) tracks consecutive com grants while any core_req is high.
- When the counter reaches MAX_COM_BURST, the next cycle grants the round-robin core even though com_req is high. The counter then clears.
- The counter also clears on any cycle with no core_req, and on rst.
- When undefined, com has strict priority and the counter is absent.

Decomposition:
- Package dm_arb_pkg holds the status encoding constants ST_COM_WR, ST_CORE, ST_COM_RD, ST_IDLE.
- Package also holds a requester-ID width function (clog2 of N_CORES+1).
- One sub-module, rr_picker: takes req vector and ptr, returns one-hot grant. Purely combinational, instantiated once for cores.

Test Plan:
- Reset, then idle with no requests -> all gnt 0, DM_write_en 0, status 11 at every cycle.
- com write addr 0x0010 data 0xBEEF, then com read 0x0010 -> com_gnt 1 each cycle; com_rvalid 1 one cycle after the read grant; com_data_out 0xBEEF; status 00 then 10.
- Both cores request reads continuously from reset -> grants alternate core0, core1, core0. Each core_rvalid follows its grant by 1 cycle with the correct data.
- com_req and core0 reads asserted in the same cycle -> com_gnt 1, core_gnt 0; core0 granted the cycle after com_req drops.
- rst asserted in the cycle after a core1 read grant -> core_rvalid stays 0; rr_ptr 0.
- With DM_ARB_STARVE_GUARD_EN, MAX_COM_BURST=8, com_req held, core1 requesting -> core1 granted on the 9th cycle, then com resumes.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared constants for the data-memory arbiter: status encoding and requester-ID sizing.
package dm_arb_pkg;

  localparam logic [1:0] ST_COM_WR = 2'b00;
  localparam logic [1:0] ST_CORE   = 2'b01;
  localparam logic [1:0] ST_COM_RD = 2'b10;
  localparam logic [1:0] ST_IDLE   = 2'b11;

  // ID 0 is the com block, IDs 1..n_cores are the cores.
  function automatic int req_id_w(input int n_cores);
    return $clog2(n_cores + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first requester at or after ptr.
module rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [N-1:0] rot_req;
  logic [N-1:0] rot_gnt;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_req = N'({req, req} >> ptr);
    rot_gnt = rot_req & (~rot_req + N'(1));
    gnt     = N'(({rot_gnt, rot_gnt} << ptr) >> N);
  end

endmodule

// File: rtl/dm_arbiter.sv
// Dynamic arbiter sharing the single-port DM between com and N cores; com has priority.
// Optional macro DM_ARB_STARVE_GUARD_EN bounds consecutive com grants while a core waits.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int N_CORES       = 2,
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int MAX_COM_BURST = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        com_req,
  input  logic                        com_wr_en,
  input  logic [ADDR_W-1:0]           com_addr,
  input  logic [DATA_W-1:0]           com_data_in,
  output logic                        com_gnt,
  output logic                        com_rvalid,
  output logic [DATA_W-1:0]           com_data_out,
  input  logic [N_CORES-1:0]          core_req,
  input  logic [N_CORES-1:0]          core_wr_en,
  input  logic [N_CORES*ADDR_W-1:0]   core_addr,
  input  logic [N_CORES*DATA_W-1:0]   core_data_in,
  output logic [N_CORES-1:0]          core_gnt,
  output logic [N_CORES-1:0]          core_rvalid,
  output logic [DATA_W-1:0]           core_data_out,
  output logic [ADDR_W-1:0]           DM_addr,
  output logic [DATA_W-1:0]           DM_data_in,
  output logic                        DM_write_en,
  input  logic [DATA_W-1:0]           DM_out,
  output logic [1:0]                  status
);

  localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int ID_W  = req_id_w(N_CORES);

  if (N_CORES < 2 || N_CORES > 8 || MAX_COM_BURST < 1) begin : g_cfg_err
    $error("dm_arbiter: unsupported N_CORES or MAX_COM_BURST");
  end

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_nxt;
  logic [PTR_W-1:0]   gnt_idx_p0;
  logic [N_CORES-1:0] rr_gnt;
  logic               any_core_req;
  logic               starve_force;
  logic               com_gnt_p0;
  logic [N_CORES-1:0] core_gnt_p0;
  logic               rd_vld_p0;
  logic [ID_W-1:0]    rd_id_p0;
  logic               rd_vld_p1;
  logic [ID_W-1:0]    rd_id_p1;
  logic [1:0]         status_q;
  logic [1:0]         status_nxt;
  logic [DATA_W-1:0]  com_hold;
  logic [DATA_W-1:0]  core_hold;

  assign any_core_req = |core_req;

  rr_picker #(.N(N_CORES), .PTR_W(PTR_W)) u_rr_picker (
    .req (core_req),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

`ifdef DM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_COM_BURST + 1);
  logic [CNT_W-1:0] burst_cnt;

  assign starve_force = any_core_req && (burst_cnt == CNT_W'(MAX_COM_BURST));

  always_ff @(posedge clk) begin
    if (rst || !any_core_req) begin
      burst_cnt <= '0;
    end else if (|core_gnt_p0) begin
      burst_cnt <= '0;
    end else if (com_gnt_p0 && !starve_force) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // Stage p0: grant decision and combinational DM drive
  always_comb begin
    com_gnt_p0  = 1'b0;
    core_gnt_p0 = '0;
    if (!rst) begin
      if (com_req && !starve_force) begin
        com_gnt_p0 = 1'b1;
      end else begin
        core_gnt_p0 = rr_gnt;
      end
    end
  end

  always_comb begin
    DM_addr     = '0;
    DM_data_in  = '0;
    DM_write_en = 1'b0;
    gnt_idx_p0  = '0;
    rd_id_p0    = '0;
    if (com_gnt_p0) begin
      DM_addr     = com_addr;
      DM_data_in  = com_data_in;
      DM_write_en = com_wr_en;
    end
    for (int i = 0; i < N_CORES; i++) begin
      if (core_gnt_p0[i]) begin
        DM_addr     = core_addr[i*ADDR_W +: ADDR_W];
        DM_data_in  = core_data_in[i*DATA_W +: DATA_W];
        DM_write_en = core_wr_en[i];
        gnt_idx_p0  = PTR_W'(i);
        rd_id_p0    = ID_W'(i + 1);
      end
    end
  end

  assign rd_vld_p0  = (com_gnt_p0 || (|core_gnt_p0)) && !DM_write_en;
  assign rr_ptr_nxt = (gnt_idx_p0 == PTR_W'(N_CORES - 1)) ? '0 : gnt_idx_p0 + PTR_W'(1);

  always_comb begin
    status_nxt = ST_IDLE;
    if (com_gnt_p0) begin
      status_nxt = com_wr_en ? ST_COM_WR : ST_COM_RD;
    end else if (|core_gnt_p0) begin
      status_nxt = ST_CORE;
    end
  end

  // Stage p1: DM read data returns; route it to the requester that issued the read
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      rd_vld_p1 <= 1'b0;
      status_q  <= ST_IDLE;
      com_hold  <= '0;
      core_hold <= '0;
    end else begin
      if (|core_gnt_p0) begin
        rr_ptr <= rr_ptr_nxt;
      end
      rd_vld_p1 <= rd_vld_p0;
      status_q  <= status_nxt;
      if (com_rvalid) begin
        com_hold <= DM_out;
      end
      if (|core_rvalid) begin
        core_hold <= DM_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    rd_id_p1 <= rd_id_p0;
  end

  always_comb begin
    core_rvalid = '0;
    for (int i = 0; i < N_CORES; i++) begin
      core_rvalid[i] = !rst && rd_vld_p1 && (rd_id_p1 == ID_W'(i + 1));
    end
  end

  // Reset forces every output to its idle value even before the first edge lands.
  assign com_rvalid    = !rst && rd_vld_p1 && (rd_id_p1 == '0);
  assign com_data_out  = rst ? '0 : (com_rvalid ? DM_out : com_hold);
  assign core_data_out = rst ? '0 : ((|core_rvalid) ? DM_out : core_hold);
  assign com_gnt       = com_gnt_p0;
  assign core_gnt      = core_gnt_p0;
  assign status        = rst ? ST_IDLE : status_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural synchronous DM model.
module tb_dm_arbiter;

  localparam int N_CORES       = 2;
  localparam int ADDR_W        = 16;
  localparam int DATA_W        = 16;
  localparam int MAX_COM_BURST = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      com_req;
  logic                      com_wr_en;
  logic [ADDR_W-1:0]         com_addr;
  logic [DATA_W-1:0]         com_data_in;
  logic                      com_gnt;
  logic                      com_rvalid;
  logic [DATA_W-1:0]         com_data_out;
  logic [N_CORES-1:0]        core_req;
  logic [N_CORES-1:0]        core_wr_en;
  logic [N_CORES*ADDR_W-1:0] core_addr;
  logic [N_CORES*DATA_W-1:0] core_data_in;
  logic [N_CORES-1:0]        core_gnt;
  logic [N_CORES-1:0]        core_rvalid;
  logic [DATA_W-1:0]         core_data_out;
  logic [ADDR_W-1:0]         DM_addr;
  logic [DATA_W-1:0]         DM_data_in;
  logic                      DM_write_en;
  logic [DATA_W-1:0]         DM_out;
  logic [1:0]                status;

  logic [DATA_W-1:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  dm_arbiter #(
    .N_CORES(N_CORES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_COM_BURST(MAX_COM_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .com_req(com_req), .com_wr_en(com_wr_en), .com_addr(com_addr), .com_data_in(com_data_in),
    .com_gnt(com_gnt), .com_rvalid(com_rvalid), .com_data_out(com_data_out),
    .core_req(core_req), .core_wr_en(core_wr_en), .core_addr(core_addr),
    .core_data_in(core_data_in), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_data_out(core_data_out),
    .DM_addr(DM_addr), .DM_data_in(DM_data_in), .DM_write_en(DM_write_en), .DM_out(DM_out),
    .status(status)
  );

  always #5 clk = ~clk;

  // Single-port synchronous DM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (DM_write_en) mem[DM_addr[7:0]] <= DM_data_in;
    DM_out <= mem[DM_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_com(input logic req, input logic wr, input logic [15:0] a, input logic [15:0] d);
    com_req     = req;
    com_wr_en   = wr;
    com_addr    = a;
    com_data_in = d;
  endtask

  initial begin
    rst = 1'b1;
    set_com(1'b0, 1'b0, 16'h0, 16'h0);
    core_req     = '0;
    core_wr_en   = '0;
    core_addr    = {16'h0031, 16'h0020};
    core_data_in = '0;

    // reset with a pending com write: nothing may be granted or written
    next_cycle; next_cycle;
    set_com(1'b1, 1'b1, 16'h0010, 16'h1111);
    settle;
    check("rst_com_gnt", com_gnt, 0);
    check("rst_dm_we", DM_write_en, 0);
    check("rst_dm_addr", DM_addr, 0);
    check("rst_status", status, 2'b11);
    check("rst_rvalid", core_rvalid, 0);
    check("rst_com_data", com_data_out, 0);
    set_com(1'b0, 1'b0, 16'h0, 16'h0);
    next_cycle;
    rst = 1'b0;

    // idle
    for (int c = 0; c < 3; c++) begin
      settle;
      check("idle_com_gnt", com_gnt, 0);
      check("idle_core_gnt", core_gnt, 0);
      check("idle_dm_we", DM_write_en, 0);
      check("idle_status", status, 2'b11);
      next_cycle;
    end

    // program load for core test locations
    set_com(1'b1, 1'b1, 16'h0020, 16'hA020);
    settle;
    check("load0_gnt", com_gnt, 1);
    next_cycle;
    set_com(1'b1, 1'b1, 16'h0031, 16'hA031);
    settle;
    check("load1_we", DM_write_en, 1);
    next_cycle;

    // com write then com read of 0x0010
    set_com(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    settle;
    check("cwr_gnt", com_gnt, 1);
    check("cwr_we", DM_write_en, 1);
    check("cwr_addr", DM_addr, 16'h0010);
    check("cwr_data", DM_data_in, 16'hBEEF);
    next_cycle;
    set_com(1'b1, 1'b0, 16'h0010, 16'h0000);
    settle;
    check("crd_gnt", com_gnt, 1);
    check("crd_we", DM_write_en, 0);
    check("crd_status_wr", status, 2'b00);
    check("crd_rvalid_early", com_rvalid, 0);
    next_cycle;
    set_com(1'b0, 1'b0, 16'h0, 16'h0);
    settle;
    check("crd_rvalid", com_rvalid, 1);
    check("crd_data", com_data_out, 16'hBEEF);
    check("crd_status_rd", status, 2'b10);
    check("crd_gnt_drop", com_gnt, 0);
    next_cycle;
    settle;
    check("crd_rvalid_pulse", com_rvalid, 0);
    check("crd_data_hold", com_data_out, 16'hBEEF);
    check("crd_status_idle", status, 2'b11);

    // both cores read continuously: 0,1,0
    core_req = 2'b11;
    settle;
    check("rr1_gnt", core_gnt, 2'b01);
    check("rr1_addr", DM_addr, 16'h0020);
    check("rr1_rvalid", core_rvalid, 2'b00);
    next_cycle;
    settle;
    check("rr2_gnt", core_gnt, 2'b10);
    check("rr2_addr", DM_addr, 16'h0031);
    check("rr2_rvalid", core_rvalid, 2'b01);
    check("rr2_data", core_data_out, 16'hA020);
    check("rr2_status", status, 2'b01);
    next_cycle;
    settle;
    check("rr3_gnt", core_gnt, 2'b01);
    check("rr3_rvalid", core_rvalid, 2'b10);
    check("rr3_data", core_data_out, 16'hA031);
    next_cycle;
    core_req = 2'b00;
    settle;
    check("rr4_gnt", core_gnt, 2'b00);
    check("rr4_rvalid", core_rvalid, 2'b01);
    check("rr4_data", core_data_out, 16'hA020);
    next_cycle;
    settle;
    check("rr5_rvalid", core_rvalid, 2'b00);
    check("rr5_hold", core_data_out, 16'hA020);
    check("rr5_status", status, 2'b11);

    // core0 write (no rvalid), then read back
    core_req     = 2'b01;
    core_wr_en   = 2'b01;
    core_addr    = {16'h0031, 16'h0040};
    core_data_in = {16'h0000, 16'h1234};
    settle;
    check("kwr_gnt", core_gnt, 2'b01);
    check("kwr_we", DM_write_en, 1);
    check("kwr_addr", DM_addr, 16'h0040);
    check("kwr_data", DM_data_in, 16'h1234);
    next_cycle;
    core_wr_en = 2'b00;
    settle;
    check("kwr_no_rvalid", core_rvalid, 2'b00);
    check("krd_we", DM_write_en, 0);
    check("kwr_status", status, 2'b01);
    next_cycle;
    core_req = 2'b00;
    settle;
    check("krd_rvalid", core_rvalid, 2'b01);
    check("krd_data", core_data_out, 16'h1234);
    next_cycle;

    // com and core0 together: com wins, core0 follows
    set_com(1'b1, 1'b0, 16'h0010, 16'h0000);
    core_req = 2'b01;
    settle;
    check("pri_com_gnt", com_gnt, 1);
    check("pri_core_gnt", core_gnt, 2'b00);
    next_cycle;
    set_com(1'b0, 1'b0, 16'h0, 16'h0);
    settle;
    check("pri_core_after", core_gnt, 2'b01);
    check("pri_com_rvalid", com_rvalid, 1);
    check("pri_com_data", com_data_out, 16'hBEEF);
    next_cycle;
    core_req = 2'b00;
    settle;
    check("pri_core_rvalid", core_rvalid, 2'b01);
    check("pri_core_data", core_data_out, 16'h1234);
    next_cycle;

    // reset right after a core1 read grant drops the read
    core_addr = {16'h0031, 16'h0020};
    core_req  = 2'b10;
    settle;
    check("mrst_gnt1", core_gnt, 2'b10);
    next_cycle;
    rst = 1'b1;
    core_req = 2'b00;
    settle;
    check("mrst_rvalid", core_rvalid, 2'b00);
    check("mrst_data", core_data_out, 0);
    check("mrst_status", status, 2'b11);
    next_cycle;
    rst = 1'b0;
    settle;
    check("mrst_rvalid_after", core_rvalid, 2'b00);

    // reset after a core0 grant must return rr_ptr to 0
    core_req = 2'b01;
    settle;
    check("mrst_gnt0", core_gnt, 2'b01);
    next_cycle;
    rst = 1'b1;
    core_req = 2'b00;
    settle;
    check("mrst0_rvalid", core_rvalid, 2'b00);
    next_cycle;
    rst = 1'b0;
    core_req = 2'b11;
    settle;
    check("mrst_ptr0", core_gnt, 2'b01);
    next_cycle;
    core_req = 2'b00;
    settle;
    check("mrst_rd_rvalid", core_rvalid, 2'b01);
    check("mrst_rd_data", core_data_out, 16'hA020);
    next_cycle;

    // com held with core1 waiting
    set_com(1'b1, 1'b0, 16'h0010, 16'h0000);
    core_req = 2'b10;
    for (int c = 1; c <= 10; c++) begin
      settle;
`ifdef DM_ARB_STARVE_GUARD_EN
      check("starve_com_gnt", com_gnt, (c == 9) ? 1'b0 : 1'b1);
      check("starve_core_gnt", core_gnt, (c == 9) ? 2'b10 : 2'b00);
      if (c == 10) begin
        check("starve_rvalid", core_rvalid, 2'b10);
        check("starve_data", core_data_out, 16'hA031);
      end
`else
      check("strict_com_gnt", com_gnt, 1);
      check("strict_core_gnt", core_gnt, 2'b00);
`endif
      next_cycle;
    end
    set_com(1'b0, 1'b0, 16'h0, 16'h0);
    core_req = 2'b00;
    next_cycle;
    next_cycle;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
